hit_ram_dumper: RTL and testbench
=================================

// Module: hit_ram_dumper
// PURPOSE
//  Event buffer downstream of the hit-collection FSM. Accepts 8-bit TDC codes
//  one per cycle and packs them little-endian into 32-bit words in a local RAM.
//  On a dump request it copies a header word and all data words into the IPbus
//  dual-port RAM, then performs a 4-phase handshake with the PC.
// PARAMETERS
//  BUF_WORDS  255  data-word capacity; header + data must fit the 8-bit IPbus address space
//  SYNC_STG   2    synchroniser flops on handshakePC
// PORTS
//  SYSCLK             in   1   system clock, the single clock of this block
//  RESET              in   1   synchronous, active-high reset
//  write_En           in   1   store data_in this cycle
//  data_in            in   8   TDC code
//  dumpMem            in   1   level dump request, held high until dumpdone is seen
//  dumpdone           out  1   1-cycle pulse at the end of the dump/handshake
//  IPbus_RAM_data     out  32  DPRAM write data
//  IPbus_RAM_address  out  8   DPRAM write address
//  IPbus_RAM_we       out  1   DPRAM write strobe
//  handshakeFPGA      out  1   high = frame ready in DPRAM
//  handshakePC        in   1   asynchronous PC acknowledge
// BEHAVIOUR
//  Reset: all outputs 0; byte count, packing register and overflow flag cleared;
//   FSM in IDLE. A reset mid-dump or mid-handshake aborts immediately and
//   drops handshakeFPGA in the next cycle.
//  Packing: byte k of the frame lands in word k/4, bits [8*(k%4)+7 : 8*(k%4)].
//   Unused bytes of a partial last word read 0.
//  byte_cnt: 16 bit; saturates at 4*BUF_WORDS (1020).
//  Write while full: byte is dropped and ovf is set (sticky until DONE).
//  Writes outside IDLE are discarded silently and do not set ovf. This drains
//   the FIFO during a dump.
//  Header word (address 0): {ovf, 15'b0, byte_cnt}.
//  Data words: addresses 1..N, where N = ceil(byte_cnt/4).
//  FSM:
//   IDLE    : dumpMem=1 and armed -> FLUSH.
//   FLUSH   : commit the partial packing word to RAM, if any -> HEADER.
//   HEADER  : IPbus_RAM_we=1, addr 0, header word -> DATA, or HS_WAIT if N=0.
//   DATA    : one word per cycle at addr 1..N, we=1; after word N -> HS_WAIT.
//   HS_WAIT : handshakeFPGA=1; synced handshakePC=1 -> HS_REL.
//   HS_REL  : handshakeFPGA=0; synced handshakePC=0 -> DONE.
//   DONE    : dumpdone=1 for one cycle; clear byte_cnt, ovf and packing -> IDLE.
//  Latency: the first we cycle (header) comes 2 cycles after dumpMem is sampled
//   high. we stays high for exactly N+1 contiguous cycles.
//   handshakeFPGA rises the cycle after the last we.
//  Re-arm: armed is cleared on leaving IDLE and set again only when dumpMem is
//   sampled low, so a dumpMem still high after DONE does not start a second dump.
//  Outputs IPbus_RAM_* are registered; address and data are stable while we=1.
//  The internal RAM has 1-cycle read latency; the RAM read for the next word is
//   issued one cycle ahead of its write.
// TESTING
//  1. Write 0x11,0x12,0x13,0x14,0x15, then dumpMem=1 -> addr0=0x00000005,
//     addr1=0x14131211, addr2=0x00000015; we high for 3 cycles; handshakeFPGA=1.
//  2. Continue test 1: PC raises then lowers handshakePC -> handshakeFPGA falls
//     after SYNC_STG+1 cycles; one dumpdone pulse; the next dump header reads 0.
//  3. Write 1021 bytes, then dump -> header 0x800003FC; addr 255 holds bytes
//     1016..1019; we high for 256 cycles.
//  4. Empty buffer dump -> single we cycle, addr0=0x00000000, then normal handshake.
//  5. Assert write_En throughout HS_WAIT, then dump again -> the second header
//     count excludes those bytes and ovf=0.
//  6. RESET in DATA and in HS_WAIT -> we and handshakeFPGA are 0 the next cycle;
//     a subsequent 2-byte frame dumps as 0x00000002 plus one data word.

Source files
------------

// File: rtl/hit_ram_dumper.sv
// Event buffer: packs 8-bit TDC codes into 32-bit words in a local RAM, then on request copies
// a header plus the data words into the IPbus DPRAM and handshakes the frame with the PC.
module hit_ram_dumper #(
    parameter int unsigned BUF_WORDS = 255,
    parameter int unsigned SYNC_STG  = 2
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        write_En,
    input  logic [7:0]  data_in,
    input  logic        dumpMem,
    output logic        dumpdone,
    output logic [31:0] IPbus_RAM_data,
    output logic [7:0]  IPbus_RAM_address,
    output logic        IPbus_RAM_we,
    output logic        handshakeFPGA,
    input  logic        handshakePC
);

    localparam logic [15:0] FullCnt  = 16'(4 * BUF_WORDS);
    localparam logic [7:0]  BufWords = 8'(BUF_WORDS);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFlush  = 3'd1;
    localparam logic [2:0] StHeader = 3'd2;
    localparam logic [2:0] StData   = 3'd3;
    localparam logic [2:0] StHsWait = 3'd4;
    localparam logic [2:0] StHsRel  = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] pack_q, pack_d, packed_word;
    logic        ovf_q, ovf_d;
    logic        armed_q, armed_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  n_words;
    logic        we_q, we_d, hs_q, hs_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic [SYNC_STG-1:0] sync_q;
    logic                pc_sync;

    logic [31:0] mem [BUF_WORDS];
    logic [31:0] rd_q;
    logic        mem_we;
    logic [7:0]  mem_waddr, rd_addr;
    logic [31:0] mem_wdata;

    assign pc_sync = sync_q[SYNC_STG-1];
    assign n_words = 8'((byte_cnt_q + 16'd3) >> 2);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        pack_d      = pack_q;
        ovf_d       = ovf_q;
        armed_d     = armed_q;
        idx_d       = idx_q;
        we_d        = 1'b0;
        hs_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        mem_we      = 1'b0;
        mem_waddr   = byte_cnt_q[9:2];
        mem_wdata   = pack_q;
        packed_word = pack_q | ({24'b0, data_in} << {byte_cnt_q[1:0], 3'b000});
        // Word i is read one cycle before it is written out
        rd_addr     = (state_q == StHeader) ? 8'd0 : idx_q + 8'd1;

        if (!dumpMem) armed_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (write_En) begin
                    if (byte_cnt_q == FullCnt) begin
                        ovf_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                        if (byte_cnt_q[1:0] == 2'd3) begin
                            mem_we    = 1'b1;
                            mem_wdata = packed_word;
                            pack_d    = '0;
                        end else begin
                            pack_d = packed_word;
                        end
                    end
                end
                if (dumpMem && armed_q) begin
                    state_d = StFlush;
                    armed_d = 1'b0;
                end
            end
            StFlush: begin
                mem_we  = (byte_cnt_q[1:0] != 2'd0);
                state_d = StHeader;
            end
            StHeader: begin
                we_d    = 1'b1;
                addr_d  = 8'd0;
                data_d  = {ovf_q, 15'b0, byte_cnt_q};
                idx_d   = 8'd0;
                state_d = (n_words == 8'd0) ? StHsWait : StData;
            end
            StData: begin
                we_d   = 1'b1;
                addr_d = idx_q + 8'd1;
                data_d = rd_q;
                idx_d  = idx_q + 8'd1;
                if (idx_q + 8'd1 == n_words) state_d = StHsWait;
            end
            StHsWait: begin
                hs_d = !pc_sync;
                if (pc_sync) state_d = StHsRel;
            end
            StHsRel: begin
                if (!pc_sync) state_d = StDone;
            end
            StDone: begin
                byte_cnt_d = '0;
                ovf_d      = 1'b0;
                pack_d     = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            pack_q     <= '0;
            ovf_q      <= 1'b0;
            armed_q    <= 1'b0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            hs_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            ovf_q      <= ovf_d;
            armed_q    <= armed_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            hs_q       <= hs_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sync_q     <= {sync_q[SYNC_STG-2:0], handshakePC};
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_q <= (rd_addr < BufWords) ? mem[rd_addr] : '0;
    end

    assign dumpdone          = (state_q == StDone);
    assign IPbus_RAM_we      = we_q;
    assign IPbus_RAM_address = addr_q;
    assign IPbus_RAM_data    = data_q;
    assign handshakeFPGA     = hs_q;

endmodule

// File: tb/tb_hit_ram_dumper.sv
// Randomized self-checking bench for hit_ram_dumper against a byte-queue frame model.
module tb_hit_ram_dumper;

    localparam int BUF_WORDS = 255;
    localparam int SYNC_STG  = 2;

    logic        SYSCLK = 1'b0;
    logic        RESET;
    logic        write_En;
    logic [7:0]  data_in;
    logic        dumpMem;
    logic        dumpdone;
    logic [31:0] IPbus_RAM_data;
    logic [7:0]  IPbus_RAM_address;
    logic        IPbus_RAM_we;
    logic        handshakeFPGA;
    logic        handshakePC;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;

    hit_ram_dumper #(
        .BUF_WORDS (BUF_WORDS),
        .SYNC_STG  (SYNC_STG)
    ) dut (
        .SYSCLK            (SYSCLK),
        .RESET             (RESET),
        .write_En          (write_En),
        .data_in           (data_in),
        .dumpMem           (dumpMem),
        .dumpdone          (dumpdone),
        .IPbus_RAM_data    (IPbus_RAM_data),
        .IPbus_RAM_address (IPbus_RAM_address),
        .IPbus_RAM_we      (IPbus_RAM_we),
        .handshakeFPGA     (handshakeFPGA),
        .handshakePC       (handshakePC)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_header();
        return {m_ovf, 15'b0, 16'(mq.size())};
    endfunction

    function automatic logic [31:0] exp_word(input int w);
        logic [31:0] r = '0;
        for (int b = 0; b < 4; b++)
            if (4 * w + b < mq.size()) r[8*b +: 8] = mq[4*w + b];
        return r;
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ovf = 1'b0;
    endfunction

    task automatic write_byte(input logic [7:0] b);
        write_En = 1'b1;
        data_in  = b;
        @(negedge SYSCLK);
        write_En = 1'b0;
        if (mq.size() < 4 * BUF_WORDS) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic write_random(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            write_byte(8'($urandom));
            if (gaps && $urandom_range(0, 3) == 0) @(negedge SYSCLK);
        end
    endtask

    // Raise dumpMem and collect the contiguous DPRAM write burst; leaves the DUT in HS_WAIT.
    task automatic do_dump(input string tag);
        int n, first, nwe;
        logic [31:0] exp;
        n     = (mq.size() + 3) / 4;
        first = -1;
        nwe   = 0;
        dumpMem = 1'b1;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge SYSCLK);
            if (IPbus_RAM_we) begin
                if (first < 0) first = c;
                exp = (nwe == 0) ? exp_header() : exp_word(nwe - 1);
                check_eq({tag, "_addr"}, 32'(IPbus_RAM_address), 32'(nwe));
                check_eq({tag, "_data"}, IPbus_RAM_data, exp);
                nwe++;
            end else if (first >= 0) begin
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(first), 32'd3);
        check_eq({tag, "_we_len"}, 32'(nwe), 32'(n + 1));
        check_eq({tag, "_hs_up"}, 32'(handshakeFPGA), 32'd1);
    endtask

    task automatic do_handshake(input string tag);
        int pulses, extra_we;
        handshakePC = 1'b1;
        for (int i = 0; i < SYNC_STG; i++) @(negedge SYSCLK);
        check_eq({tag, "_hs_hold"}, 32'(handshakeFPGA), 32'd1);
        @(negedge SYSCLK);
        check_eq({tag, "_hs_fall"}, 32'(handshakeFPGA), 32'd0);
        handshakePC = 1'b0;
        pulses   = 0;
        extra_we = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge SYSCLK);
            if (dumpdone) pulses++;
            if (IPbus_RAM_we || handshakeFPGA) extra_we++;
        end
        check_eq({tag, "_done_pulses"}, 32'(pulses), 32'd1);
        check_eq({tag, "_no_redump"}, 32'(extra_we), 32'd0);
        dumpMem = 1'b0;
        model_clear();
        @(negedge SYSCLK);
    endtask

    initial begin
        RESET       = 1'b1;
        write_En    = 1'b0;
        data_in     = '0;
        dumpMem     = 1'b0;
        handshakePC = 1'b0;
        repeat (3) @(negedge SYSCLK);
        check_eq("rst_we", 32'(IPbus_RAM_we), 32'd0);
        check_eq("rst_hs", 32'(handshakeFPGA), 32'd0);
        check_eq("rst_done", 32'(dumpdone), 32'd0);
        check_eq("rst_addr", 32'(IPbus_RAM_address), 32'd0);
        check_eq("rst_data", IPbus_RAM_data, 32'd0);
        RESET = 1'b0;
        @(negedge SYSCLK);

        // Five-byte frame
        for (int i = 0; i < 5; i++) write_byte(8'(8'h11 + i));
        do_dump("t1");
        do_handshake("t2");

        // Empty frame
        do_dump("t4");
        do_handshake("t4");

        // Overflowing frame
        write_random(1021, 1'b0);
        do_dump("t3");
        do_handshake("t3");

        // Writes during HS_WAIT are discarded
        write_random(7, 1'b1);
        do_dump("t5a");
        write_En = 1'b1;
        data_in  = 8'($urandom);
        repeat (10) @(negedge SYSCLK);
        write_En = 1'b0;
        do_handshake("t5a");
        write_random(3, 1'b0);
        do_dump("t5b");
        do_handshake("t5b");

        // Random frames
        for (int f = 0; f < 4; f++) begin
            write_random($urandom_range(0, 60), 1'b1);
            do_dump("rnd");
            do_handshake("rnd");
        end

        // Reset in DATA
        write_random(20, 1'b0);
        dumpMem = 1'b1;
        repeat (4) @(negedge SYSCLK);
        RESET = 1'b1;
        @(negedge SYSCLK);
        check_eq("t6_data_we", 32'(IPbus_RAM_we), 32'd0);
        check_eq("t6_data_hs", 32'(handshakeFPGA), 32'd0);
        RESET   = 1'b0;
        dumpMem = 1'b0;
        model_clear();
        @(negedge SYSCLK);

        // Reset in HS_WAIT
        write_random(3, 1'b0);
        do_dump("t6w");
        RESET = 1'b1;
        @(negedge SYSCLK);
        check_eq("t6_wait_we", 32'(IPbus_RAM_we), 32'd0);
        check_eq("t6_wait_hs", 32'(handshakeFPGA), 32'd0);
        RESET   = 1'b0;
        dumpMem = 1'b0;
        model_clear();
        @(negedge SYSCLK);

        write_random(2, 1'b0);
        do_dump("t6b");
        do_handshake("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
